// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Bus layouts for the fetch-to-decode and branch-redirect interfaces.
package if_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h1c00_0000;
    localparam int FS_TO_DS_WD = 64;
    localparam int BR_TO_FS_WD = 33;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_to_ds_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_t;

endpackage

// File: rtl/if_stage_skid_buf.sv
// One-entry instruction buffer holding SRAM read data across decode stalls.
// Selects the held copy over the live SRAM output while it is valid.
module if_stage_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        cap_i,
    input  logic [31:0] rdata_i,
    output logic        buf_valid_o,
    output logic [31:0] inst_o
);

    logic        buf_valid_q;
    logic [31:0] buf_inst_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_inst_q  <= 32'h0;
        end else if (clr_i) begin
            buf_valid_q <= 1'b0;
        end else if (cap_i) begin
            buf_valid_q <= 1'b1;
            buf_inst_q  <= rdata_i;
        end
    end

    assign buf_valid_o = buf_valid_q;
    assign inst_o      = buf_valid_q ? buf_inst_q : rdata_i;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM,
// absorbs decode back-pressure and applies each taken branch once.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ds_allow_in,
    input  logic [BR_TO_FS_WD-1:0] br_bus,
    output logic                   fs_to_ds_valid,
    output logic [FS_TO_DS_WD-1:0] fs_to_ds_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_we,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    input  logic [31:0]            inst_sram_rdata
);

    br_t         br;
    fs_to_ds_t   fs_out;
    logic        fs_valid_q;
    logic [31:0] fs_pc_q;
    logic        br_used_q;
    logic        eff_br;
    logic [31:0] nextpc;
    logic        fs_ready_go;
    logic        fs_allow_in;
    logic        issue;
    logic        to_ds;
    logic        buf_valid;
    logic        buf_clr;
    logic        buf_cap;
    logic [31:0] fs_inst;

    assign br          = br_t'(br_bus);
    assign eff_br      = br.taken && !br_used_q;
    assign nextpc      = eff_br ? br.target : fs_pc_q + 32'd4;
    assign fs_ready_go = 1'b1;
    assign fs_allow_in = !fs_valid_q || (fs_ready_go && ds_allow_in);
    assign issue       = !rst && fs_allow_in;

    // The instruction sitting in IF is wrong-path whenever a redirect is live.
    assign fs_to_ds_valid = fs_valid_q && !eff_br;
    assign to_ds          = fs_to_ds_valid && ds_allow_in;

    assign inst_sram_en    = issue;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fs_valid_q <= 1'b0;
            fs_pc_q    <= RESET_PC - 32'd4;
            br_used_q  <= 1'b0;
        end else begin
            if (issue) begin
                fs_valid_q <= 1'b1;
                fs_pc_q    <= nextpc;
            end else if (eff_br) begin
                fs_valid_q <= 1'b0;
            end
            // Clearing wins: the branch leaves decode in this cycle.
            br_used_q <= ds_allow_in ? 1'b0 : (br_used_q | (eff_br && issue));
        end
    end

    assign buf_clr = issue || eff_br || to_ds;
    assign buf_cap = fs_valid_q && !buf_valid && !to_ds && !eff_br;

    if_stage_skid_buf u_skid (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (buf_clr),
        .cap_i       (buf_cap),
        .rdata_i     (inst_sram_rdata),
        .buf_valid_o (buf_valid),
        .inst_o      (fs_inst)
    );

    assign fs_out.pc    = fs_pc_q;
    assign fs_out.inst  = fs_inst;
    assign fs_to_ds_bus = fs_out;

endmodule
